// File: rtl/sfq_harness_pkg.sv
// Shared types for the toggle-encoded RSFQ test harness: capture FSM states
// and bit positions of the packed error vector.
package sfq_harness_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int ERR_W        = 4;
    localparam int ERR_MULTI    = 0;
    localparam int ERR_ORPHAN   = 1;
    localparam int ERR_OVERFLOW = 2;
    localparam int ERR_STALL    = 3;

endpackage

// File: rtl/sfq_toggle_detect.sv
// Per-wire toggle detector: a level change between consecutive clk edges is
// one SFQ pulse.
module sfq_toggle_detect (
    input  logic clk,
    input  logic level,
    output logic tog
);

    logic level_q;

    // The register tracks the input in reset as well, so releasing reset never
    // produces a spurious toggle; no reset branch is needed.
    always_ff @(posedge clk) begin
        level_q <= level;
    end

    assign tog = level ^ level_q;

endmodule

// File: rtl/sfq_toggle_deserializer.sv
// Decodes one bit per toggle-encoded cell-clock period, packs bits LSB-first
// into words on a valid/ready port and raises sticky protocol error flags.
module sfq_toggle_deserializer
    import sfq_harness_pkg::*;
#(
    parameter int WORD_W  = 8,
    parameter int MAX_GAP = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sfq_clk,
    input  logic              sfq_out,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              err_multi,
    output logic              err_orphan,
    output logic              err_overflow,
    output logic              err_stall,
    input  logic              err_clr
);

    localparam int BIT_W = $clog2(WORD_W);
    localparam int GAP_W = $clog2(MAX_GAP + 1);

    logic [1:0] levels;
    logic [1:0] togs;
    logic       tog_c;
    logic       tog_o;

    assign levels = {sfq_out, sfq_clk};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_det
            sfq_toggle_detect u_det (
                .clk   (clk),
                .level (levels[gi]),
                .tog   (togs[gi])
            );
        end
    endgenerate

    assign tog_c = togs[0];
    assign tog_o = togs[1];

    state_t            state_reg,      state_next;
    logic [WORD_W-1:0] shift_reg,      shift_next;
    logic [BIT_W-1:0]  bit_idx_reg,    bit_idx_next;
    logic [1:0]        pc_reg,         pc_next;
    logic [GAP_W-1:0]  gap_reg,        gap_next;
    logic [WORD_W-1:0] word_data_reg,  word_data_next;
    logic              word_valid_reg, word_valid_next;
    logic [ERR_W-1:0]  err_reg,        err_next;

    logic [WORD_W-1:0] assembled;
    logic [ERR_W-1:0]  err_set;
    logic [GAP_W-1:0]  gap_inc;
    logic              word_done;
    logic              pop;

    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        bit_idx_next    = bit_idx_reg;
        pc_next         = pc_reg;
        gap_next        = gap_reg;
        word_data_next  = word_data_reg;
        word_valid_next = word_valid_reg;
        assembled       = shift_reg;
        err_set         = '0;
        word_done       = 1'b0;
        gap_inc         = gap_reg + GAP_W'(1);
        pop             = word_valid_reg && word_ready;

        case (state_reg)
            IDLE: begin
                if (tog_o) begin
                    err_set[ERR_ORPHAN] = 1'b1;
                end
                if (tog_c) begin
                    state_next   = ACTIVE;
                    pc_next      = 2'd0;
                    gap_next     = '0;
                    bit_idx_next = '0;
                    shift_next   = '0;
                end
            end
            default: begin
                if (tog_c) begin
                    // Clock closes the old period first; a coincident out
                    // pulse belongs to the period being opened.
                    assembled[bit_idx_reg] = (pc_reg != 2'd0);
                    if (pc_reg >= 2'd2) begin
                        err_set[ERR_MULTI] = 1'b1;
                    end
                    if (bit_idx_reg == BIT_W'(WORD_W - 1)) begin
                        word_done    = 1'b1;
                        bit_idx_next = '0;
                        shift_next   = '0;
                    end else begin
                        bit_idx_next = bit_idx_reg + BIT_W'(1);
                        shift_next   = assembled;
                    end
                    pc_next  = tog_o ? 2'd1 : 2'd0;
                    gap_next = '0;
                end else if (gap_inc == GAP_W'(MAX_GAP)) begin
                    err_set[ERR_STALL] = 1'b1;
                    state_next   = IDLE;
                    bit_idx_next = '0;
                    shift_next   = '0;
                    pc_next      = 2'd0;
                    gap_next     = '0;
                end else begin
                    gap_next = gap_inc;
                    if (tog_o) begin
                        pc_next = (pc_reg == 2'd2) ? 2'd2 : pc_reg + 2'd1;
                    end
                end
            end
        endcase

        if (word_done) begin
            if (!word_valid_reg || pop) begin
                word_data_next  = assembled;
                word_valid_next = 1'b1;
            end else begin
                err_set[ERR_OVERFLOW] = 1'b1;
            end
        end else if (pop) begin
            word_valid_next = 1'b0;
        end

        err_next = (err_clr ? '0 : err_reg) | err_set;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            bit_idx_reg    <= '0;
            pc_reg         <= 2'd0;
            gap_reg        <= '0;
            word_data_reg  <= '0;
            word_valid_reg <= 1'b0;
            err_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            bit_idx_reg    <= bit_idx_next;
            pc_reg         <= pc_next;
            gap_reg        <= gap_next;
            word_data_reg  <= word_data_next;
            word_valid_reg <= word_valid_next;
            err_reg        <= err_next;
        end
    end

    assign word_data    = word_data_reg;
    assign word_valid   = word_valid_reg;
    assign err_multi    = err_reg[ERR_MULTI];
    assign err_orphan   = err_reg[ERR_ORPHAN];
    assign err_overflow = err_reg[ERR_OVERFLOW];
    assign err_stall    = err_reg[ERR_STALL];

endmodule

// File: tb/tb_sfq_toggle_deserializer.sv
// Directed bench for sfq_toggle_deserializer with WORD_W=4, MAX_GAP=16.
module tb_sfq_toggle_deserializer;
    import sfq_harness_pkg::*;

    localparam int WORD_W  = 4;
    localparam int MAX_GAP = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sfq_clk = 1'b0;
    logic              sfq_out = 1'b0;
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready = 1'b1;
    logic              err_multi;
    logic              err_orphan;
    logic              err_overflow;
    logic              err_stall;
    logic              err_clr = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    sfq_toggle_deserializer #(
        .WORD_W  (WORD_W),
        .MAX_GAP (MAX_GAP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sfq_clk      (sfq_clk),
        .sfq_out      (sfq_out),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .err_multi    (err_multi),
        .err_orphan   (err_orphan),
        .err_overflow (err_overflow),
        .err_stall    (err_stall),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    function automatic logic [31:0] errs();
        logic [31:0] e;
        e = '0;
        e[ERR_MULTI]    = err_multi;
        e[ERR_ORPHAN]   = err_orphan;
        e[ERR_OVERFLOW] = err_overflow;
        e[ERR_STALL]    = err_stall;
        return e;
    endfunction

    function automatic logic [31:0] ebit(input int idx);
        logic [31:0] e;
        e = '0;
        e[idx] = 1'b1;
        return e;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clk_tog();
        sfq_clk = ~sfq_clk;
        cyc(1);
    endtask

    task automatic out_tog();
        sfq_out = ~sfq_out;
        cyc(1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    initial begin
        // Reset while both inputs toggle, then release with inputs static.
        rst_n = 1'b0;
        repeat (3) begin
            sfq_clk = ~sfq_clk;
            sfq_out = ~sfq_out;
            cyc(1);
        end
        rst_n = 1'b1;
        cyc(3);
        chk("rst_word_data", 32'(word_data), 32'h0);
        chk("rst_word_valid", 32'(word_valid), 32'h0);
        chk("rst_errs", errs(), 32'h0);
        chk("rst_state", 32'(dut.state_reg), 32'(IDLE));

        // Word 0101: pulses in periods 0 and 2, clock every 10 cycles.
        do_reset();
        word_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            clk_tog();
            if (p == 0 || p == 2) begin
                cyc(2);
                out_tog();
                cyc(6);
            end else begin
                cyc(9);
            end
        end
        clk_tog();
        chk("w0101_valid", 32'(word_valid), 32'h1);
        chk("w0101_data", 32'(word_data), 32'h5);
        cyc(1);
        chk("w0101_valid_drop", 32'(word_valid), 32'h0);
        chk("w0101_data_hold", 32'(word_data), 32'h5);
        chk("w0101_errs", errs(), 32'h0);

        // Double pulse in period 1, then coincident clock+out closes it.
        do_reset();
        clk_tog();
        cyc(9);
        clk_tog();
        cyc(2);
        out_tog();
        cyc(2);
        out_tog();
        cyc(3);
        sfq_clk = ~sfq_clk;
        sfq_out = ~sfq_out;
        cyc(1);
        chk("multi_flag", errs(), ebit(ERR_MULTI));
        cyc(5);
        clk_tog();
        cyc(5);
        clk_tog();
        chk("multi_word_valid", 32'(word_valid), 32'h1);
        chk("multi_word_data", 32'(word_data), 32'h6);
        chk("multi_errs_sticky", errs(), ebit(ERR_MULTI));

        // Out pulse before any clock, err_clr interplay, then an empty word.
        do_reset();
        out_tog();
        chk("orphan_set", errs(), ebit(ERR_ORPHAN));
        err_clr = 1'b1;
        out_tog();
        err_clr = 1'b0;
        chk("orphan_clr_vs_new", errs(), ebit(ERR_ORPHAN));
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("orphan_cleared", errs(), 32'h0);
        clk_tog();
        for (int p = 0; p < 4; p++) begin
            cyc(3);
            clk_tog();
        end
        chk("orphan_word_valid", 32'(word_valid), 32'h1);
        chk("orphan_word_data", 32'(word_data), 32'h0);

        // Consumer stalled across two complete words.
        do_reset();
        word_ready = 1'b0;
        clk_tog();
        for (int p = 0; p < 8; p++) begin
            cyc(2);
            out_tog();
            cyc(2);
            clk_tog();
            if (p == 3) begin
                chk("ovf_first_valid", 32'(word_valid), 32'h1);
                chk("ovf_first_data", 32'(word_data), 32'hF);
                chk("ovf_first_errs", errs(), 32'h0);
            end
        end
        chk("ovf_flag", errs(), ebit(ERR_OVERFLOW));
        chk("ovf_held_valid", 32'(word_valid), 32'h1);
        chk("ovf_held_data", 32'(word_data), 32'hF);
        word_ready = 1'b1;
        cyc(1);
        chk("ovf_pop_valid", 32'(word_valid), 32'h0);
        cyc(2);
        chk("ovf_no_second", 32'(word_valid), 32'h0);
        chk("ovf_sticky", errs(), ebit(ERR_OVERFLOW));

        // Stall after two pulsed periods, then restart without stale bits.
        do_reset();
        word_ready = 1'b1;
        clk_tog();
        cyc(1);
        out_tog();
        cyc(1);
        clk_tog();
        cyc(1);
        out_tog();
        cyc(1);
        clk_tog();
        cyc(MAX_GAP - 1);
        chk("stall_not_yet", errs(), 32'h0);
        chk("stall_state_active", 32'(dut.state_reg), 32'(ACTIVE));
        cyc(1);
        chk("stall_flag", errs(), ebit(ERR_STALL));
        chk("stall_state_idle", 32'(dut.state_reg), 32'(IDLE));
        chk("stall_no_word", 32'(word_valid), 32'h0);
        clk_tog();
        for (int p = 0; p < 4; p++) begin
            cyc(3);
            clk_tog();
        end
        chk("stall_word_valid", 32'(word_valid), 32'h1);
        chk("stall_word_data", 32'(word_data), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
